load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the word-addressed data memory interface (Address, WriteData, MemWrite, MemRead, ReadData). The block accepts byte, halfword and word load/store requests from the CPU datapath and converts them into word-wide memory accesses. Sub-word stores are done as read-modify-write. It returns sign- or zero-extended load data and flags misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the attached memory; word index = addr>>2; index >= MEM_WORDS is an error.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept; high only in IDLE.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle completion pulse; no backpressure.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_error  out  1  valid with resp_valid; misaligned, out-of-range or size 11.
mem_Address  out  32  word-aligned address {addr[31:2],2'b00}.
mem_WriteData  out  32  full word to write.
mem_MemWrite  out  1  memory write enable; the memory samples it on posedge clk.
mem_MemRead  out  1  memory read enable; the memory returns data combinationally.
mem_ReadData  in  32  word from memory.

Behaviour:
- Little-endian lanes: byte k = bits [8k+7:8k]; half at addr[1]=1 = bits [31:16].
- States: IDLE, READ, WRITE, RESP. All request fields are latched on accept (req_valid && req_ready).
- Memory outputs are decoded from state and the latched fields:
  - MemRead = 1 only in READ.
  - MemWrite = 1 only in WRITE.
  - Address is driven in READ and WRITE; otherwise 0.
  - WriteData is driven only in WRITE; otherwise 0.
- IDLE transitions on accept:
  - Error condition → RESP, no memory access. Error = (half && addr[0]) || (word && addr[1:0]!=0) || size==11 || (addr>>2) >= MEM_WORDS.
  - Word store → WRITE.
  - Any load or sub-word store → READ.
- READ: at posedge, capture mem_ReadData into rdata_q. Then go to RESP for a load, WRITE for a sub-word store.
- WRITE: WriteData = req_wdata for a word store. For a sub-word store it is rdata_q with only the addressed byte or half lane replaced. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - Load: resp_rdata = extracted lane, extended per req_unsigned.
  - Store or error: resp_rdata = 0.
  - resp_error = latched error flag.
- Latency, with accept at edge 0 and cycles counted from that edge:
  - Error: resp cycle 1.
  - Word store: WRITE cycle 1, resp cycle 2.
  - Load: READ cycle 1, resp cycle 2.
  - Sub-word store: READ 1, WRITE 2, resp 3.
- req_ready=0 in READ, WRITE and RESP. A request held from RESP is accepted in the next IDLE cycle.
- Reset, asynchronous:
  - Forces IDLE and clears rdata_q and the latched fields.
  - Outputs immediately: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, all mem_* outputs 0.
- Reset mid-operation aborts the access. If asserted during READ or WRITE before the write edge, the memory word is unchanged, and no response is issued for the aborted request.
- Memory is never written for a load or an error request.

Test Plan:
1. Word 3 = 0x11223344. sw addr 0x0C, data 0xDEADBEEF → MemWrite=1 only in cycle 1 with Address 0x0C; resp_valid cycle 2, error 0. Then lw 0x0C → resp_rdata 0xDEADBEEF at cycle 2.
2. Word 3 = 0x80FF7F01, loads from it:
   - lb 0x0F → 0xFFFFFF80; lbu 0x0F → 0x00000080.
   - lb 0x0C → 0x00000001.
   - lh 0x0E → 0xFFFF80FF; lhu 0x0E → 0x000080FF.
3. Word 3 = 0x11223344. sb 0x0D, data 0x123456AA → MemRead cycle 1, MemWrite cycle 2 with WriteData 0x1122AA44, resp cycle 3. sh 0x0E, data 0xBEEF → memory word 0xBEEF3344.
4. Errors, each giving resp_valid cycle 1, error 1, rdata 0, MemRead/MemWrite never asserted:
   - lw 0x0E, sh 0x0D, size 11 at 0x00 (misaligned / invalid size).
   - lw 0x80 with MEM_WORDS=32 (out of range).
5. Word 3 = 0x11223344, sb 0x0D in progress; assert reset during READ (cycle 1) → all outputs 0 immediately, memory word still 0x11223344, req_ready=1 after release, no resp_valid.
6. req_valid held high with two back-to-back lw (0x00 then 0x04) → second accepted the cycle after the first RESP; two resp_valid pulses 3 cycles apart; req_ready never high outside IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word-wide memory
// accesses, doing read-modify-write for sub-word stores and extending loads.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_WriteData,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_ReadData,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Handshake: a request is taken on any posedge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no backpressure.
  logic [1:0]  r_state;
  logic        r_write;
  logic        r_unsigned;
  logic        r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata_q;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_lane;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_accept = req_valid && req_ready;
  assign w_err = (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                 (req_size == 2'b11) ||
                 ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata_q  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_err      <= w_err;
            if (w_err)                              r_state <= S_RESP;
            else if (req_write && req_size == 2'b10) r_state <= S_WRITE;
            else                                     r_state <= S_READ;
          end
        end
        S_READ: begin
          r_rdata_q <= mem_ReadData;
          r_state   <= r_write ? S_WRITE : S_RESP;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shift the addressed lane down to bit 0, then extend per size/signedness.
  always_comb begin
    w_lane = r_rdata_q >> {r_addr[1:0], 3'b000};
    w_ext  = r_rdata_q;
    case (r_size)
      2'b00:   w_ext = r_unsigned ? {24'd0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_ext = r_unsigned ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_ext = r_rdata_q;
    endcase
  end

  always_comb begin
    w_merge = r_rdata_q;
    case (r_size)
      2'b00: begin
        case (r_addr[1:0])
          2'd0:    w_merge[7:0]   = r_wdata[7:0];
          2'd1:    w_merge[15:8]  = r_wdata[7:0];
          2'd2:    w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign resp_error    = (r_state == S_RESP) && r_err;
  assign resp_rdata    = (r_state == S_RESP && !r_write && !r_err) ? w_ext : 32'd0;
  assign mem_MemRead   = (r_state == S_READ);
  assign mem_MemWrite  = (r_state == S_WRITE);
  assign mem_Address   = (r_state == S_READ || r_state == S_WRITE) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mem_WriteData = (r_state == S_WRITE) ? w_merge : 32'd0;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, directed request steps,
// and a response scoreboard fed when each request is driven.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_Address;
  logic [31:0] mem_WriteData;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic [31:0] mem_ReadData;
  logic [1:0]  dbg_state;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model
  logic [31:0] mem [0:31];
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  int          n_wr;
  assign mem_ReadData = mem[mem_Address[6:2]];
  always @(posedge clk) begin
    if (mem_MemWrite) begin
      mem[mem_Address[6:2]] = mem_WriteData;
      last_waddr = mem_Address;
      last_wdata = mem_WriteData;
      n_wr = n_wr + 1;
    end
  end

  // scoreboard: {error, rdata}
  logic [32:0] exp_q[$];
  int n_cmp;
  int n_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_error", 32'(resp_error), 32'(e[32]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request from IDLE; exp_rd_cyc / exp_wr_cyc = -1 means never.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er,
                        input int exp_lat, input int exp_rd_cyc, input int exp_wr_cyc);
    int cyc;
    int rd_cyc;
    int wr_cyc;
    int nwr0;
    bit got;
    bit bad_ready;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    nwr0 = n_wr;
    exp_q.push_back({exp_er, exp_rd});
    tick();
    req_valid = 1'b0;
    cyc = 1; rd_cyc = -1; wr_cyc = -1; got = 0; bad_ready = 0;
    while (!got && cyc < 10) begin
      if (mem_MemRead && rd_cyc < 0) rd_cyc = cyc;
      if (mem_MemWrite && wr_cyc < 0) wr_cyc = cyc;
      if (req_ready) bad_ready = 1;
      if (resp_valid) got = 1;
      else begin
        tick();
        cyc++;
      end
    end
    check({tag, "_resp_cycle"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, "_read_cycle"}, 32'(rd_cyc), 32'(exp_rd_cyc));
    check({tag, "_write_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
    check({tag, "_ready_busy"}, 32'(bad_ready), 32'd0);
    tick();
    check({tag, "_write_count"}, 32'(n_wr - nwr0), (exp_wr_cyc >= 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; n_wr = 0;
    last_waddr = 32'd0; last_wdata = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_ctrl", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("rst_mem_addr", mem_Address, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();

    // word store then load back
    mem[3] = 32'h1122_3344;
    do_req("sw", 1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, -1, 1);
    check("sw_addr", last_waddr, 32'h0000_000C);
    check("sw_mem", mem[3], 32'hDEAD_BEEF);
    do_req("lw", 1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 1, -1);

    // extension cases
    mem[3] = 32'h80FF_7F01;
    do_req("lb_f",  1'b0, 2'b00, 1'b0, 32'h0F, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 1, -1);
    do_req("lbu_f", 1'b0, 2'b00, 1'b1, 32'h0F, 32'd0, 32'h0000_0080, 1'b0, 2, 1, -1);
    do_req("lb_c",  1'b0, 2'b00, 1'b0, 32'h0C, 32'd0, 32'h0000_0001, 1'b0, 2, 1, -1);
    do_req("lb_d",  1'b0, 2'b00, 1'b0, 32'h0D, 32'd0, 32'h0000_007F, 1'b0, 2, 1, -1);
    do_req("lh_e",  1'b0, 2'b01, 1'b0, 32'h0E, 32'd0, 32'hFFFF_80FF, 1'b0, 2, 1, -1);
    do_req("lhu_e", 1'b0, 2'b01, 1'b1, 32'h0E, 32'd0, 32'h0000_80FF, 1'b0, 2, 1, -1);
    do_req("lh_c",  1'b0, 2'b01, 1'b0, 32'h0C, 32'd0, 32'h0000_7F01, 1'b0, 2, 1, -1);

    // sub-word stores via read-modify-write
    mem[3] = 32'h1122_3344;
    do_req("sb_d", 1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234_56AA, 32'd0, 1'b0, 3, 1, 2);
    check("sb_wdata", last_wdata, 32'h1122_AA44);
    check("sb_mem", mem[3], 32'h1122_AA44);
    mem[3] = 32'h1122_3344;
    do_req("sh_e", 1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_BEEF, 32'd0, 1'b0, 3, 1, 2);
    check("sh_mem", mem[3], 32'hBEEF_3344);

    // errors: no memory access, response in cycle 1
    mem[3] = 32'h1122_3344;
    do_req("err_lw_e",  1'b0, 2'b10, 1'b0, 32'h0E, 32'd0, 32'd0, 1'b1, 1, -1, -1);
    do_req("err_sh_d",  1'b1, 2'b01, 1'b0, 32'h0D, 32'h0000_BEEF, 32'd0, 1'b1, 1, -1, -1);
    do_req("err_sz11",  1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 32'd0, 1'b1, 1, -1, -1);
    do_req("err_range", 1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 32'd0, 1'b1, 1, -1, -1);
    check("err_mem", mem[3], 32'h1122_3344);

    // reset during READ of a sub-word store
    mem[3] = 32'h1122_3344;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0D; req_wdata = 32'h1234_56AA;
    tick();
    req_valid = 1'b0;
    check("abort_in_read", 32'(mem_MemRead), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_resp", {30'd0, resp_valid, resp_error}, 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    check("abort_mem_ctrl", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("abort_mem_addr", mem_Address, 32'd0);
    check("abort_mem_wdata", mem_WriteData, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("abort_ready_after", 32'(req_ready), 32'd1);
    repeat (4) tick();
    check("abort_mem", mem[3], 32'h1122_3344);

    // back-to-back loads with valid held high
    mem[0] = 32'hA5A5_0001;
    mem[1] = 32'h5A5A_0002;
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    exp_q.push_back({1'b0, 32'h5A5A_0002});
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h00; req_wdata = 32'd0;
    tick();
    req_addr = 32'h04;
    begin
      int r1;
      int r2;
      r1 = -1; r2 = -1;
      for (int c = 1; c <= 6; c++) begin
        if (c == 4) req_valid = 1'b0;
        check($sformatf("b2b_ready_c%0d", c), 32'(req_ready), (c == 3 || c == 6) ? 32'd1 : 32'd0);
        if (resp_valid) begin
          if (r1 < 0) r1 = c;
          else if (r2 < 0) r2 = c;
        end
        tick();
      end
      check("b2b_first_resp", 32'(r1), 32'd2);
      check("b2b_second_resp", 32'(r2), 32'd5);
    end

    // random aligned word loads
    for (int k = 0; k < 4; k++) begin
      int idx;
      logic [31:0] v;
      idx = $urandom_range(0, 31);
      v = $urandom;
      mem[idx] = v;
      do_req($sformatf("rnd_lw%0d", k), 1'b0, 2'b10, 1'b0, 32'(idx) << 2, 32'd0, v, 1'b0, 2, 1, -1);
    end

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
